// File: rtl/uart_tx.sv
// UART transmitter: a TX FIFO (or single holding register) feeding a tick-driven
// start/data/parity/stop serialiser with break, CTS gating and a soft reset.
module uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               apb_clk_in,
  input  logic               apb_rst_in,
  input  logic               bclk_in,
  input  logic [7:0]         thr_data_in,
  input  logic               thr_wr_in,
  input  logic               utrst_in,
  input  logic               txclr_in,
  input  logic               fifoen_in,
  input  logic [1:0]         wls_in,
  input  logic               stb_in,
  input  logic               pen_in,
  input  logic               eps_in,
  input  logic               sp_in,
  input  logic               bc_in,
  input  logic               osm_in,
  input  logic               afe_in,
  input  logic               cts_in,
  output logic               txd_out,
  output logic               thre_out,
  output logic               temt_out,
  output logic [FIFO_AW:0]   fifo_cnt_out
);

  localparam int CNT_W = FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Frame format captured at frame start; eps/sp are folded into par_q then.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       osm;
  } frame_cfg_t;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cap;
  logic               full, push, pop, can_start;
  logic [7:0]         head, head_masked;

  state_e             state_q, state_d;
  logic [4:0]         tick_q, tick_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  frame_cfg_t         cfg_q, cfg_d;
  logic               txd_q, txd_d;
  logic [4:0]         per_m1, stop_m1;
  logic               line;

  assign cap         = fifoen_in ? CNT_W'(FIFO_DEPTH) : CNT_W'(1);
  assign full        = (cnt_q >= cap);
  assign can_start   = (cnt_q != '0) && (!afe_in || cts_in);
  assign head        = mem_q[rd_ptr_q];
  assign head_masked = head & (8'hFF >> (2'd3 - wls_in));

  // Last tick index of a bit period and of the stop interval (1, 1.5 or 2 bits).
  always_comb begin
    per_m1 = cfg_q.osm ? 5'd12 : 5'd15;
    if (!cfg_q.stb)             stop_m1 = per_m1;
    else if (cfg_q.wls == 2'd0) stop_m1 = cfg_q.osm ? 5'd19 : 5'd23;
    else                        stop_m1 = cfg_q.osm ? 5'd25 : 5'd31;
  end

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    cfg_d   = cfg_q;
    pop     = 1'b0;

    if (!utrst_in) begin
      state_d = S_IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else if (bclk_in) begin
      case (state_q)
        S_IDLE: pop = can_start;
        S_START: begin
          if (tick_q == per_m1) begin
            tick_d  = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
        S_DATA: begin
          if (tick_q == per_m1) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == {1'b0, cfg_q.wls} + 3'd4) begin
              bit_d   = '0;
              state_d = cfg_q.pen ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
        S_PARITY: begin
          if (tick_q == per_m1) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
        S_STOP: begin
          if (tick_q == stop_m1) begin
            tick_d  = '0;
            state_d = S_IDLE;
            pop     = can_start;  // back-to-back frames: no idle tick between them
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (pop) begin
        state_d = S_START;
        tick_d  = '0;
        bit_d   = '0;
        shift_d = head;
        cfg_d   = '{wls: wls_in, stb: stb_in, pen: pen_in, osm: osm_in};
        par_d   = sp_in ? ~eps_in : (eps_in ? ^head_masked : ~^head_masked);
      end
    end

    case (state_d)
      S_START:  line = 1'b0;
      S_DATA:   line = shift_d[0];
      S_PARITY: line = par_d;
      default:  line = 1'b1;
    endcase
    txd_d = bc_in ? 1'b0 : line;
  end

  always_comb begin
    push     = thr_wr_in && utrst_in && !txclr_in && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (!utrst_in || txclr_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      cfg_q    <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      cfg_q    <= cfg_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is not reset; entries are only read when cnt_q says they were written.
  always_ff @(posedge apb_clk_in) begin
    if (push) mem_q[wr_ptr_q] <= thr_data_in;
  end

  assign txd_out      = txd_q;
  assign thre_out     = (cnt_q == '0);
  assign temt_out     = (cnt_q == '0) && (state_q == S_IDLE);
  assign fifo_cnt_out = cnt_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frame table and corner sequences,
// plus randomized traffic checked every cycle against a tick-level frame model.
module tb_uart_tx;

  logic       apb_clk_in = 1'b0;
  logic       apb_rst_in, bclk_in, thr_wr_in, utrst_in, txclr_in, fifoen_in;
  logic [7:0] thr_data_in;
  logic [1:0] wls_in;
  logic       stb_in, pen_in, eps_in, sp_in, bc_in, osm_in, afe_in, cts_in;
  logic       txd_out, thre_out, temt_out;
  logic [4:0] fifo_cnt_out;

  uart_tx #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .apb_clk_in(apb_clk_in), .apb_rst_in(apb_rst_in), .bclk_in(bclk_in),
    .thr_data_in(thr_data_in), .thr_wr_in(thr_wr_in), .utrst_in(utrst_in),
    .txclr_in(txclr_in), .fifoen_in(fifoen_in), .wls_in(wls_in), .stb_in(stb_in),
    .pen_in(pen_in), .eps_in(eps_in), .sp_in(sp_in), .bc_in(bc_in), .osm_in(osm_in),
    .afe_in(afe_in), .cts_in(cts_in), .txd_out(txd_out), .thre_out(thre_out),
    .temt_out(temt_out), .fifo_cnt_out(fifo_cnt_out)
  );

  always #5 apb_clk_in = ~apb_clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Sample-tick source: every cycle for directed tests, sparse for random traffic.
  logic bclk_all = 1'b1;
  always @(negedge apb_clk_in) bclk_in = bclk_all ? 1'b1 : ($urandom_range(0, 2) == 0);

  // ---------------- reference model: byte queue + per-tick line waveform ----------------
  logic [7:0] mq[$];
  bit         mwave[$];
  bit         mbusy = 1'b0;
  bit         mline = 1'b1;
  logic       exp_txd = 1'b1;

  function automatic void build_frame(input logic [7:0] b);
    int per, nb, ones, stop_t;
    bit par;
    per  = osm_in ? 13 : 16;
    nb   = 5 + int'(wls_in);
    ones = 0;
    for (int t = 0; t < per; t++) mwave.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      ones += int'(b[i]);
      for (int t = 0; t < per; t++) mwave.push_back(b[i]);
    end
    if (pen_in) begin
      par = sp_in ? !eps_in : (eps_in ? (ones % 2 == 1) : (ones % 2 == 0));
      for (int t = 0; t < per; t++) mwave.push_back(par);
    end
    stop_t = !stb_in ? per : ((wls_in == 2'd0) ? (3 * per + 1) / 2 : 2 * per);
    for (int t = 0; t < stop_t; t++) mwave.push_back(1'b1);
  endfunction

  always @(posedge apb_clk_in) begin
    int pre, cap;
    bit popped;
    if (apb_rst_in) begin
      mq.delete(); mwave.delete(); mbusy = 0; mline = 1; exp_txd = 1'b1;
    end else if (!utrst_in) begin
      mq.delete(); mwave.delete(); mbusy = 0; mline = 1; exp_txd = !bc_in;
    end else begin
      pre    = mq.size();
      popped = 0;
      if (bclk_in) begin
        if (mbusy && mwave.size() > 0) mline = mwave.pop_front();
        else begin
          mbusy = 0;
          mline = 1;
          if (pre > 0 && (!afe_in || cts_in)) begin
            build_frame(mq.pop_front());
            popped = 1;
            mbusy  = 1;
            mline  = mwave.pop_front();
          end
        end
      end
      cap = fifoen_in ? 16 : 1;
      if (thr_wr_in && !txclr_in && (pre < cap || popped)) mq.push_back(thr_data_in);
      if (txclr_in) mq.delete();
      exp_txd = bc_in ? 1'b0 : mline;
    end
    #1;
    check("m_txd",  32'(txd_out),      32'(exp_txd));
    check("m_cnt",  32'(fifo_cnt_out), 32'(mq.size()));
    check("m_thre", 32'(thre_out),     32'(mq.size() == 0));
    check("m_temt", 32'(temt_out),     32'(mq.size() == 0 && !mbusy));
  end

  // ---------------- directed helpers ----------------
  logic s_txd  [0:4095];
  logic s_temt [0:4095];

  task automatic write_byte(input logic [7:0] b);
    @(negedge apb_clk_in);
    thr_data_in = b;
    thr_wr_in   = 1'b1;
    @(negedge apb_clk_in);
    thr_wr_in   = 1'b0;
  endtask

  // Samples txd/temt just after each of n+1 edges; optional mid-frame CTS drop and break window.
  task automatic run_frame(input int n, input int cts_drop, input int bc_on, input int bc_off);
    for (int j = 0; j <= n; j++) begin
      @(posedge apb_clk_in);
      #1;
      s_txd[j]  = txd_out;
      s_temt[j] = temt_out;
      if (j == cts_drop) cts_in = 1'b0;
      if (j == bc_on)    bc_in  = 1'b1;
      if (j == bc_off)   bc_in  = 1'b0;
    end
  endtask

  function automatic logic bit_8n1(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic set_cfg(input logic [1:0] w, input logic st, input logic pe, input logic ep,
                         input logic s, input logic o);
    wls_in = w; stb_in = st; pen_in = pe; eps_in = ep; sp_in = s; osm_in = o;
  endtask

  typedef struct {
    logic [1:0]  wls;
    logic        stb, pen, eps, sp, osm;
    logic [7:0]  data;
    logic [15:0] bits;   // line value of each full bit slot, slot 0 = start
    int          slots;
    int          total;  // frame length in ticks
  } vec_t;

  vec_t vecs[5];

  initial begin
    int per, ones_cnt;
    logic [7:0] b;

    vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 16'h034A, 10, 160};
    vecs[1] = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 16'h00E6,  8, 111};
    vecs[2] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5B, 16'h06B6, 11, 176};
    vecs[3] = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 16'h017E,  9, 117};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 16'h0054,  7, 120};

    apb_rst_in = 1'b1; bclk_in = 1'b0; thr_wr_in = 1'b0; thr_data_in = '0;
    utrst_in = 1'b1; txclr_in = 1'b0; fifoen_in = 1'b1; bc_in = 1'b0;
    afe_in = 1'b0; cts_in = 1'b1;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge apb_clk_in);
    check("rst_txd",  32'(txd_out), 32'd1);
    check("rst_thre", 32'(thre_out), 32'd1);
    check("rst_temt", 32'(temt_out), 32'd1);
    check("rst_cnt",  32'(fifo_cnt_out), 32'd0);
    apb_rst_in = 1'b0;

    // Frame-format table
    for (int v = 0; v < 5; v++) begin
      @(negedge apb_clk_in);
      set_cfg(vecs[v].wls, vecs[v].stb, vecs[v].pen, vecs[v].eps, vecs[v].sp, vecs[v].osm);
      write_byte(vecs[v].data);
      run_frame(vecs[v].total, -1, -1, -1);
      per = vecs[v].osm ? 13 : 16;
      for (int i = 0; i < vecs[v].slots; i++)
        check($sformatf("vec%0d_slot%0d", v, i), 32'(s_txd[i*per + per/2]), 32'(vecs[v].bits[i]));
      check($sformatf("vec%0d_stop_end_txd", v),  32'(s_txd[vecs[v].total-1]),  32'd1);
      check($sformatf("vec%0d_busy_to_end", v),   32'(s_temt[vecs[v].total-1]), 32'd0);
      check($sformatf("vec%0d_temt_at_end", v),   32'(s_temt[vecs[v].total]),   32'd1);
    end

    // Fill 16 + 1 with the shifter blocked, then drain back-to-back
    @(negedge apb_clk_in);
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    afe_in = 1'b1; cts_in = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge apb_clk_in);
      thr_data_in = 8'(k);
      thr_wr_in   = 1'b1;
    end
    @(negedge apb_clk_in);
    thr_wr_in = 1'b0;
    check("fill_cnt",  32'(fifo_cnt_out), 32'd16);
    check("fill_txd",  32'(txd_out),      32'd1);
    cts_in = 1'b1;
    run_frame(16 * 160, -1, -1, -1);
    for (int k = 0; k < 16; k++) begin
      b = 8'(k);
      check($sformatf("b2b%0d_start_edge", k), 32'(s_txd[k*160]), 32'd0);
      for (int i = 0; i < 10; i++)
        check($sformatf("b2b%0d_bit%0d", k, i), 32'(s_txd[k*160 + i*16 + 8]), 32'(bit_8n1(b, i)));
    end
    check("b2b_busy_to_end", 32'(s_temt[2559]), 32'd0);
    check("b2b_temt_end",    32'(s_temt[2560]), 32'd1);

    // CTS gating at frame start only
    @(negedge apb_clk_in);
    cts_in = 1'b0;
    write_byte(8'h3C);
    ones_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge apb_clk_in);
      #1;
      ones_cnt += int'(txd_out);
    end
    check("cts_hold_txd_high", 32'(ones_cnt), 32'd30);
    check("cts_hold_thre",     32'(thre_out), 32'd0);
    @(negedge apb_clk_in);
    cts_in = 1'b1;
    run_frame(160, 50, -1, -1);
    for (int i = 0; i < 10; i++)
      check($sformatf("cts_bit%0d", i), 32'(s_txd[i*16 + 8]), 32'(bit_8n1(8'h3C, i)));
    check("cts_start_next_tick", 32'(s_txd[0]),   32'd0);
    check("cts_busy_to_end",     32'(s_temt[159]), 32'd0);
    check("cts_temt_end",        32'(s_temt[160]), 32'd1);
    @(negedge apb_clk_in);
    afe_in = 1'b0; cts_in = 1'b1;

    // Break during DATA does not stretch the frame
    write_byte(8'hA5);
    run_frame(160, -1, 39, 49);
    ones_cnt = 0;
    for (int j = 40; j <= 49; j++) ones_cnt += int'(s_txd[j]);
    check("brk_forced_low", 32'(ones_cnt), 32'd0);
    check("brk_release",    32'(s_txd[50]), 32'(bit_8n1(8'hA5, 3)));
    for (int i = 0; i < 10; i++)
      if (i != 2) check($sformatf("brk_bit%0d", i), 32'(s_txd[i*16 + 8]), 32'(bit_8n1(8'hA5, i)));
    check("brk_busy_to_end", 32'(s_temt[159]), 32'd0);
    check("brk_temt_end",    32'(s_temt[160]), 32'd1);

    // Mid-frame reset, then mid-frame soft reset through utrst_in
    for (int r = 0; r < 2; r++) begin
      write_byte(8'hA5);
      write_byte(8'h5A);
      repeat (60) @(negedge apb_clk_in);
      check($sformatf("abort%0d_pre_cnt", r), 32'(fifo_cnt_out), 32'd1);
      if (r == 0) apb_rst_in = 1'b1;
      else        utrst_in   = 1'b0;
      @(posedge apb_clk_in);
      #1;
      check($sformatf("abort%0d_txd", r),  32'(txd_out),      32'd1);
      check($sformatf("abort%0d_cnt", r),  32'(fifo_cnt_out), 32'd0);
      check($sformatf("abort%0d_thre", r), 32'(thre_out),     32'd1);
      check($sformatf("abort%0d_temt", r), 32'(temt_out),     32'd1);
      @(negedge apb_clk_in);
      apb_rst_in = 1'b0; utrst_in = 1'b1;
      ones_cnt = 0;
      for (int j = 0; j < 40; j++) begin
        @(posedge apb_clk_in);
        #1;
        ones_cnt += int'(txd_out);
      end
      check($sformatf("abort%0d_no_partial", r), 32'(ones_cnt), 32'd40);
    end

    // Holding-register mode capacity and clear with a same-cycle write
    @(negedge apb_clk_in);
    fifoen_in = 1'b0; afe_in = 1'b1; cts_in = 1'b0;
    write_byte(8'h11);
    write_byte(8'h22);
    check("hold_cap_cnt",  32'(fifo_cnt_out), 32'd1);
    check("hold_cap_thre", 32'(thre_out),     32'd0);
    @(negedge apb_clk_in);
    txclr_in = 1'b1; thr_wr_in = 1'b1; thr_data_in = 8'h33;
    @(negedge apb_clk_in);
    txclr_in = 1'b0; thr_wr_in = 1'b0;
    check("clr_cnt",  32'(fifo_cnt_out), 32'd0);
    check("clr_temt", 32'(temt_out),     32'd1);
    fifoen_in = 1'b1; afe_in = 1'b0; cts_in = 1'b1;

    // Randomized traffic; the model above checks every cycle
    for (int c = 0; c < 8000; c++) begin
      @(negedge apb_clk_in);
      bclk_all    = (c < 4000);
      thr_wr_in   = (c < 4000) ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 3) == 0);
      thr_data_in = 8'($urandom);
      txclr_in    = ($urandom_range(0, 399) == 0);
      utrst_in    = ($urandom_range(0, 599) != 0);
      apb_rst_in  = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 59) == 0)  cts_in    = !cts_in;
      if ($urandom_range(0, 299) == 0) afe_in    = !afe_in;
      if ($urandom_range(0, 499) == 0) fifoen_in = !fifoen_in;
      if ($urandom_range(0, 79) == 0)
        set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (bc_in) bc_in = ($urandom_range(0, 3) != 0);
      else       bc_in = ($urandom_range(0, 399) == 0);
    end
    @(negedge apb_clk_in);
    thr_wr_in = 1'b0; txclr_in = 1'b0; apb_rst_in = 1'b0; utrst_in = 1'b1; bc_in = 1'b0;
    repeat (4) @(negedge apb_clk_in);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  FIFO_DEPTH, 16, TX FIFO entries (power of 2)
  FIFO_AW, 4, log2(FIFO_DEPTH)
REQ-002 Clock is apb_clk_in; reset is apb_rst_in, synchronous, active-high. Ports, one per line (name direction width meaning):
  apb_clk_in  in  1  single clock
  apb_rst_in  in  1  sync active-high reset
  bclk_in  in  1  one-cycle sample-tick enable from the baud generator (16x/13x baud)
  thr_data_in  in  8  byte written to THR
  thr_wr_in  in  1  one-cycle THR write strobe
  utrst_in  in  1  1 = transmitter enabled; 0 = held in reset
  txclr_in  in  1  one-cycle TX FIFO clear
  fifoen_in  in  1  1 = FIFO mode; 0 = single holding register
  wls_in  in  2  word length 00=5 .. 11=8 bits
  stb_in  in  1  0 = 1 stop; 1 = 2 stop (1.5 when wls=00)
  pen_in  in  1  parity enable
  eps_in  in  1  1 = even parity, 0 = odd
  sp_in  in  1  stick parity
  bc_in  in  1  break control
  osm_in  in  1  0 = 16 ticks/bit, 1 = 13 ticks/bit
  afe_in  in  1  auto flow control enable
  cts_in  in  1  clear-to-send, active-high, pre-synchronised
  txd_out  out  1  serial output, registered
  thre_out  out  1  FIFO/holding register empty
  temt_out  out  1  FIFO empty and shifter idle
  fifo_cnt_out  out  FIFO_AW+1  current occupancy

Function
REQ-003 Effective capacity SHALL be FIFO_DEPTH when fifoen_in=1 and 1 when fifoen_in=0.
REQ-004 thr_wr_in while not full SHALL push thr_data_in; while full, the write SHALL be dropped with no state change.
REQ-005 A simultaneous pop and write SHALL both take effect, including when full; count is unchanged.
REQ-006 txclr_in SHALL empty the FIFO next cycle; an in-flight frame SHALL complete; a same-cycle write SHALL be discarded.
REQ-007 FSM states: IDLE, START, DATA, PARITY, STOP. All tick counting SHALL advance only on cycles with bclk_in=1.
REQ-008 IDLE->START on a bclk_in cycle with FIFO non-empty, utrst_in=1, and (afe_in=0 or cts_in=1); that cycle SHALL pop the head into the shifter and latch wls/stb/pen/eps/sp/osm for the whole frame.
REQ-009 Bit period = 16 ticks (osm=0) or 13 ticks (osm=1); START drives 0 for one bit period.
REQ-010 DATA SHALL send 5+wls bits LSB first, then go to PARITY if pen=1, else to STOP.
REQ-011 Parity bit: sp=0 -> even (eps=1) or odd (eps=0) over the data bits; sp=1 -> constant ~eps.
REQ-012 STOP drives 1 for 1 bit (stb=0), 2 bits (stb=1), or 1.5 bits (stb=1, wls=00: 24 ticks at 16x, 20 at 13x), then returns to IDLE; a new frame MAY start on the next eligible tick (back-to-back, no gap).
REQ-013 CTS SHALL be checked only at frame start; deasserting it mid-frame SHALL NOT abort the frame.
REQ-014 bc_in=1 SHALL force txd_out=0 on the next clock regardless of state; the FSM SHALL keep running; txd_out resumes FSM value one cycle after bc_in=0.
REQ-015 txd_out SHALL be 1 in IDLE (absent break) and SHALL be registered.
REQ-016 thre_out = (count==0); temt_out = (count==0 and state==IDLE); both combinational from registers.
REQ-017 utrst_in=0 SHALL, on the next clock, force IDLE, empty the FIFO, clear tick/bit counters, and set txd_out=1 (bc_in still overrides).

Reset
REQ-018 apb_rst_in=1 SHALL set on the next edge: state IDLE, FIFO empty, pointers/counters 0, txd_out=1, thre_out=1, temt_out=1, fifo_cnt_out=0.
REQ-019 Reset mid-frame SHALL abort the frame immediately; no partial bits after reset.

Verification
REQ-020 wls=11, pen=0, stb=0, osm=0, write 0xA5 -> txd: 0, then 1,0,1,0,0,1,0,1, then 1; each bit 16 ticks; 160 ticks total; temt_out rises at return to IDLE.
REQ-021 wls=00, pen=1, eps=1, sp=0, stb=1, osm=1, write 0x13 -> bits 1,1,0,0,1, parity 1, stop 1 for 20 ticks; 13 ticks per other bit.
REQ-022 fifoen=1, 17 writes of 0x00..0x10 with shifter blocked (afe=1, cts=0) -> fifo_cnt_out=16, 0x10 dropped; set cts=1 -> 0x00..0x0F sent back-to-back in order, no idle gap.
REQ-023 afe=1, cts=0, one byte queued -> txd_out stays 1 and thre_out=0; cts=1 -> START on next tick; cts=0 mid-frame -> frame completes.
REQ-024 bc_in=1 during DATA -> txd_out=0 next cycle; release -> remaining bits on schedule, total frame length unchanged.
REQ-025 apb_rst_in pulse during DATA -> txd_out=1, fifo_cnt_out=0, thre_out=temt_out=1 next cycle; repeat with utrst_in=0 -> same result.
